// File: rtl/cpu_data_mem_responder.sv
// Memory-side responder for the CPU data-memory channels: delayed request accept,
// byte-strobed writes into a word RAM, and a held read response with a valid/ready handshake.
module cpu_data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int REQ_LAT    = 1,
  parameter int RESP_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        proto_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    REQ_WAIT,
    ACK,
    RESP_WAIT,
    RESP
  } state_t;

  state_t                  state_reg;
  logic [3:0]              cnt_reg;
  logic [31:0]             ram [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    req;
  logic                    wr_accept;
  logic                    unused_addr;

  assign idx         = Address[ADDR_WIDTH+1:2];
  assign req         = MemRead | MemWrite;
  // Ready is high exactly while in ACK, so this is the write accept edge.
  assign wr_accept   = (state_reg == ACK) && MemWrite;
  assign unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  // RAM contents are deliberately left out of reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int b = 0; b < 4; b++) begin
        if (Write_strb[b]) begin
          ram[idx][8*b +: 8] <= Write_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      Mem_Req_Ready   <= 1'b0;
      Read_data_Valid <= 1'b0;
      Read_data       <= '0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      proto_err       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            cnt_reg   <= 4'(REQ_LAT);
            state_reg <= REQ_WAIT;
          end
        end
        REQ_WAIT: begin
          if (!req) begin
            state_reg <= IDLE;
          end else if (cnt_reg == 4'd0) begin
            state_reg     <= ACK;
            Mem_Req_Ready <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ACK: begin
          Mem_Req_Ready <= 1'b0;
          state_reg     <= IDLE;
          // A simultaneous read+write is served as a write only and flagged.
          if (MemWrite) begin
            wr_cnt <= wr_cnt + 32'd1;
            if (MemRead) begin
              proto_err <= 1'b1;
            end
          end else if (MemRead) begin
            Read_data <= ram[idx];
            rd_cnt    <= rd_cnt + 32'd1;
            cnt_reg   <= 4'(RESP_LAT);
            state_reg <= RESP_WAIT;
          end
        end
        RESP_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg       <= RESP;
            Read_data_Valid <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (Read_data_Ready) begin
            Read_data_Valid <= 1'b0;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_data_mem_responder.sv
// Randomized scoreboard bench for cpu_data_mem_responder: a driver issues requests and
// queues expected read responses from a word-array model; a monitor checks responses.
module tb_cpu_data_mem_responder;

  localparam int ADDR_WIDTH = 10;
  localparam int REQ_LAT    = 1;
  localparam int RESP_LAT   = 2;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready = 1'b0;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        proto_err;

  cpu_data_mem_responder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .REQ_LAT    (REQ_LAT),
    .RESP_LAT   (RESP_LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .Address         (Address),
    .MemWrite        (MemWrite),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .MemRead         (MemRead),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } resp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          resp_done = 0;
  int          force_hold = -1;
  int          exp_rd = 0;
  int          exp_wr = 0;
  logic        exp_perr = 1'b0;
  resp_t       exp_q [$];
  logic [31:0] mdl [int];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int word_of(logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic void mdl_write(logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    logic [31:0] w;
    w = mdl.exists(word_of(addr)) ? mdl[word_of(addr)] : 32'hxxxxxxxx;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    end
    mdl[word_of(addr)] = w;
  endfunction

  // Monitor: checks each response against the queue and the valid/ready protocol.
  bit          in_resp = 0;
  bit          prev_rdy = 0;
  int          hold = 0;
  logic [31:0] held;
  always @(negedge clk) begin
    if (!rst) begin
      in_resp = 0;
      prev_rdy = 0;
      Read_data_Ready = 1'b0;
    end else if (in_resp) begin
      chk("valid_level", {31'd0, Read_data_Valid}, prev_rdy ? 32'd0 : 32'd1);
      chk("resp_data_stable", Read_data, held);
      if (!Read_data_Valid) begin
        in_resp = 0;
        prev_rdy = 0;
        resp_done++;
        Read_data_Ready = 1'($urandom_range(0, 1));
      end else begin
        Read_data_Ready = (hold == 0);
        if (hold > 0) hold--;
        prev_rdy = Read_data_Ready;
      end
    end else if (Read_data_Valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'd0, Read_data_Valid}, 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_data", Read_data, e.data);
        chk("resp_latency", cyc, e.cyc);
      end
      in_resp = 1;
      held = Read_data;
      hold = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 3));
      Read_data_Ready = (hold == 0);
      if (hold > 0) hold--;
      prev_rdy = Read_data_Ready;
    end else begin
      Read_data_Ready = 1'($urandom_range(0, 1));
    end
  end

  // drop_at: -1 hold until accepted, 0 drop while waiting, 1 drop during the Ready cycle.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input int drop_at, input bit wait_resp);
    bit seen;
    int target;
    target = resp_done + 1;
    @(negedge clk);
    $display("txn rd=%0d wr=%0d addr=0x%08h data=0x%08h strb=%b drop=%0d",
             rd, wr, addr, data, strb, drop_at);
    MemRead = rd; MemWrite = wr; Address = addr; Write_data = data; Write_strb = strb;
    if (drop_at == 0) begin
      @(negedge clk);
      MemRead = 0; MemWrite = 0;
      repeat (REQ_LAT + 3) begin
        @(negedge clk);
        chk("abort_no_ready", {31'd0, Mem_Req_Ready}, 32'd0);
      end
    end else begin
      seen = 0;
      for (int k = 0; k < REQ_LAT + 8 && !seen; k++) begin
        @(negedge clk);
        if (Mem_Req_Ready) begin
          seen = 1;
          chk("ready_latency", k, REQ_LAT + 1);
        end
      end
      if (!seen) begin
        chk("ready_timeout", {31'd0, Mem_Req_Ready}, 32'd1);
        MemRead = 0; MemWrite = 0;
        return;
      end
      if (drop_at == 1) begin
        MemRead = 0; MemWrite = 0;
        @(negedge clk);
        chk("ack_drop_ready", {31'd0, Mem_Req_Ready}, 32'd0);
      end else begin
        @(negedge clk);
        MemRead = 0; MemWrite = 0;
        chk("ready_pulse", {31'd0, Mem_Req_Ready}, 32'd0);
        if (wr) begin
          mdl_write(addr, data, strb);
          exp_wr++;
          if (rd) begin
            exp_perr = 1'b1;
            repeat (RESP_LAT + 3) begin
              @(negedge clk);
              chk("proto_no_valid", {31'd0, Read_data_Valid}, 32'd0);
            end
          end
        end else begin
          exp_q.push_back('{data: mdl[word_of(addr)], cyc: cyc + RESP_LAT + 1});
          exp_rd++;
          if (wait_resp) begin
            for (int k = 0; k < 200 && resp_done < target; k++) @(negedge clk);
            if (resp_done < target) chk("resp_timeout", resp_done, target);
          end
        end
      end
    end
    chk("rd_cnt", rd_cnt, exp_rd);
    chk("wr_cnt", wr_cnt, exp_wr);
    chk("proto_err", {31'd0, proto_err}, {31'd0, exp_perr});
  endtask

  initial begin
    int idx_set [8];
    rst = 1'b0; MemRead = 0; MemWrite = 0;
    Address = '0; Write_data = '0; Write_strb = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, Mem_Req_Ready}, 32'd0);
    chk("rst_valid", {31'd0, Read_data_Valid}, 32'd0);
    chk("rst_perr", {31'd0, proto_err}, 32'd0);
    chk("rst_rdata", Read_data, 32'd0);
    chk("rst_rd_cnt", rd_cnt, 32'd0);
    chk("rst_wr_cnt", wr_cnt, 32'd0);
    rst = 1'b1;

    do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, -1, 1);
    force_hold = 0;
    do_req(1, 0, 32'h10, 32'h0, 4'b0000, -1, 1);
    // Byte store of 0xAA at 0x11: the byte sits in lane 1 of the write bus.
    do_req(0, 1, 32'h11, 32'h0000AA00, 4'b0010, -1, 1);
    do_req(1, 0, 32'h10, 32'h0, 4'b0000, -1, 1);
    force_hold = 5;
    do_req(1, 0, 32'h10, 32'h0, 4'b0000, -1, 1);
    force_hold = -1;
    do_req(1, 0, 32'h10, 32'h0, 4'b0000, 0, 1);
    do_req(1, 1, 32'h20, 32'h12345678, 4'b1111, -1, 1);
    do_req(0, 1, 32'h10, 32'h0, 4'b0000, -1, 1);
    do_req(1, 0, 32'h20, 32'h0, 4'b0000, -1, 1);

    // Asynchronous reset while a response is being held.
    force_hold = 1000;
    do_req(1, 0, 32'h10, 32'h0, 4'b0000, -1, 0);
    for (int k = 0; k < 20 && !Read_data_Valid; k++) @(negedge clk);
    chk("rst_mid_valid_seen", {31'd0, Read_data_Valid}, 32'd1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async_valid", {31'd0, Read_data_Valid}, 32'd0);
    chk("async_ready", {31'd0, Mem_Req_Ready}, 32'd0);
    chk("async_rd_cnt", rd_cnt, 32'd0);
    chk("async_perr", {31'd0, proto_err}, 32'd0);
    exp_q.delete(); exp_rd = 0; exp_wr = 0; exp_perr = 1'b0; force_hold = -1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    do_req(1, 0, 32'h10, 32'h0, 4'b0000, -1, 1);

    // Random phase over a few words, with aliased upper address bits.
    for (int i = 0; i < 8; i++) begin
      idx_set[i] = int'($urandom_range(0, DEPTH - 1));
      do_req(0, 1, 32'(idx_set[i]) << 2, $urandom, 4'b1111, -1, 1);
    end
    for (int i = 0; i < 60; i++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 9));
      a = ($urandom & 32'hFFFF_F000) | (32'(idx_set[$urandom_range(0, 7)]) << 2)
          | 32'($urandom_range(0, 3));
      if (op <= 3)      do_req(0, 1, a, $urandom, 4'($urandom_range(0, 15)), -1, 1);
      else if (op <= 6) do_req(1, 0, a, 32'h0, 4'b0000, -1, 1);
      else if (op == 7) do_req(1'($urandom_range(0, 1)), 1, a, $urandom, 4'hF, 0, 1);
      else if (op == 8) do_req(1, 1'($urandom_range(0, 1)), a, $urandom, 4'hF, 1, 1);
      else              do_req(1, 1, a, $urandom, 4'($urandom_range(0, 15)), -1, 1);
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
